// File: rtl/j68_divu_seq.sv
// Sequential unsigned 32/16 divider for DIVU.W. It borrows the shared 32-bit add/sub stage
// for one trial subtraction per cycle, which gives a quotient bit per ITER step.
module j68_divu_seq #(
    parameter int unsigned ITER_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        overflow,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        add_sub,
    output logic [31:0] add_dataa,
    output logic [31:0] add_datab,
    input  logic        add_cout,
    input  logic [31:0] add_result
);

    localparam int unsigned LAST_STEP = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         d_q, d_d;
    logic [16:0]         r_q, r_d;
    logic [15:0]         q_q, q_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic                busy_d, done_d, div_zero_d, overflow_d;
    logic [15:0]         quotient_d, remainder_d;

    logic [16:0]         shift_val;
    logic [16:0]         r_step;
    logic [15:0]         q_step;
    logic                unused_hi;

    // R < D holds on every step, so the difference never reaches bit 17.
    assign unused_hi = ^add_result[31:17];

    // Shift the next dividend bit into the partial remainder, then keep or replace it.
    always_comb begin
        shift_val = {r_q[15:0], q_q[15]};
        if (add_cout) begin
            r_step = add_result[16:0];
            q_step = {q_q[14:0], 1'b1};
        end else begin
            r_step = shift_val;
            q_step = {q_q[14:0], 1'b0};
        end
    end

    // Operands for the shared adder; quiet whenever the divider does not own it.
    always_comb begin
        add_sub   = 1'b0;
        add_dataa = 32'd0;
        add_datab = 32'd0;
        case (state_q)
            CHECK: begin
                add_dataa = {16'd0, r_q[15:0]};
                add_datab = {16'd0, d_q};
            end
            ITER: begin
                add_dataa = {15'd0, shift_val};
                add_datab = {16'd0, d_q};
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        div_zero_d  = div_zero;
        overflow_d  = overflow;
        quotient_d  = quotient;
        remainder_d = remainder;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d        = divisor;
                    r_d        = {1'b0, dividend[31:16]};
                    q_d        = dividend[15:0];
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = CHECK;
                    if (divisor == 16'd0) begin
                        div_zero_d  = 1'b1;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        quotient_d  = dividend[15:0];
                        remainder_d = dividend[31:16];
                        state_d     = DONE;
                    end
                end
            end
            CHECK: begin
                // Upper dividend half >= divisor means the quotient needs more than 16 bits.
                if (add_cout) begin
                    overflow_d  = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_q;
                    remainder_d = r_q[15:0];
                    state_d     = DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + ITER_W'(1);
                if (cnt_q == ITER_W'(LAST_STEP)) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_step;
                    remainder_d = r_step[15:0];
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            d_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            div_zero  <= div_zero_d;
            overflow  <= overflow_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
        end
    end

endmodule
